// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
// Command-issue stage that sits in front of the ALU datapath. Requests are
// queued in a small FIFO. One request at a time is issued to the ALU control
// inputs and held for ALU_LAT cycles. The ALU result is then captured and
// presented downstream on a valid/ready interface.
//
// Ports
//   clk         system clock, rising edge
//   clr         synchronous active-low reset
//   in_valid    request valid
//   in_ready    request FIFO not full
//   in_op       opcode (0..12 defined, 13..15 reserved)
//   in_acc_b    B operand taken from the ALU accumulator
//   in_a/in_b   16-bit operands
//   alu_rst     ALU control rst (one-cycle pulse for CLRACC)
//   noOp        ALU control noOp (low only while a command is issued)
//   cmd         ALU control cmd = {acc_b, op}
//   op_a/op_b   operands to the ALU A/B registers
//   alu_result  32-bit ALU output
//   res_valid   result valid
//   res_ready   downstream accepts the result
//   res_data    captured result
//   res_op      opcode of the captured result
//   res_err     result is an error (reserved opcode or divide by zero)
//   busy        sequencer not idle
// ---------------------------------------------------------------------------
module alu_issue_seq #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic        in_acc_b,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        alu_rst,
    output logic        noOp,
    output logic [4:0]  cmd,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    input  logic [31:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_op,
    output logic        res_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // FIFO entry layout: {acc_b, op[3:0], a[15:0], b[15:0]}
    logic [36:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    state_t        state_r;
    logic [LW-1:0] lat_cnt_r;
    logic          alu_rst_r;
    logic          noop_r;
    logic [4:0]    cmd_r;
    logic [15:0]   op_a_r;
    logic [15:0]   op_b_r;
    logic          res_valid_r;
    logic [31:0]   res_data_r;
    logic [3:0]    res_op_r;
    logic          res_err_r;
    logic          busy_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [36:0]   head_s;
    logic          head_acc_s;
    logic [3:0]    head_op_s;
    logic [15:0]   head_a_s;
    logic [15:0]   head_b_s;
    logic          head_div0_s;

    assign full_s   = (count_r == CW'(DEPTH));
    assign empty_s  = (count_r == {CW{1'b0}});
    assign in_ready = ~full_s;
    // Full blocks a push even when a pop happens in the same cycle.
    assign push_s   = in_valid & ~full_s;
    assign pop_s    = (state_r == ST_IDLE) & ~empty_s;

    assign head_s      = mem_r[rd_ptr_r];
    assign head_acc_s  = head_s[36];
    assign head_op_s   = head_s[35:32];
    assign head_a_s    = head_s[31:16];
    assign head_b_s    = head_s[15:0];
    // With acc_b set the divisor lives in the ALU, so it cannot be checked here.
    assign head_div0_s = (head_op_s == 4'd3) & ~head_acc_s & (head_b_s == 16'h0000);

    assign alu_rst   = alu_rst_r;
    assign noOp      = noop_r;
    assign cmd       = cmd_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_op    = res_op_r;
    assign res_err   = res_err_r;
    assign busy      = busy_r;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (clr && push_s) begin
            mem_r[wr_ptr_r] <= {in_acc_b, in_op, in_a, in_b};
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue sequencer: pops, drives ALU control, captures and holds the result
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= {LW{1'b0}};
            alu_rst_r   <= 1'b0;
            noop_r      <= 1'b1;
            cmd_r       <= 5'd0;
            op_a_r      <= 16'h0000;
            op_b_r      <= 16'h0000;
            res_valid_r <= 1'b0;
            res_data_r  <= 32'h0000_0000;
            res_op_r    <= 4'd0;
            res_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // CLRACC pulse lasts one cycle unless another CLRACC follows.
                    alu_rst_r <= 1'b0;
                    if (!empty_s) begin
                        if (head_op_s == 4'd12) begin
                            alu_rst_r <= 1'b1;
                            noop_r    <= 1'b1;
                        end else if (head_op_s > 4'd12) begin
                            res_data_r  <= 32'h0000_0000;
                            res_err_r   <= 1'b1;
                            res_op_r    <= head_op_s;
                            res_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else if (head_div0_s) begin
                            res_data_r  <= 32'hFFFF_FFFF;
                            res_err_r   <= 1'b1;
                            res_op_r    <= 4'd3;
                            res_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            cmd_r     <= {head_acc_s, head_op_s};
                            op_a_r    <= head_a_s;
                            op_b_r    <= head_b_s;
                            noop_r    <= 1'b0;
                            lat_cnt_r <= LW'(ALU_LAT - 1);
                            busy_r    <= 1'b1;
                            state_r   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (lat_cnt_r == {LW{1'b0}}) begin
                        res_data_r  <= alu_result;
                        res_op_r    <= cmd_r[3:0];
                        res_err_r   <= 1'b0;
                        res_valid_r <= 1'b1;
                        noop_r      <= 1'b1;
                        cmd_r       <= 5'd0;
                        state_r     <= ST_HOLD;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LW'(1);
                        state_r   <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    alu_rst_r   <= 1'b0;
                    noop_r      <= 1'b1;
                    cmd_r       <= 5'd0;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Command-issue stage directly upstream of the ALU datapath. It buffers operation requests in a small FIFO and drives the ALU control inputs: rst, noOp, cmd[4:0], plus the A/B operands.
- It waits a fixed ALU latency, captures the 32-bit ALU result, and presents it downstream on a valid/ready interface.
- Only one operation is in flight at a time.

Parameters:
- DEPTH, 4: request FIFO entries (power of 2, ≥2).
- ALU_LAT, 1: cycles an issued command is held before the ALU result is sampled (≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request FIFO not full.
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 NAND, 11 NOR, 12 CLRACC, 13-15 reserved.
- in_acc_b  in  1  B operand comes from the accumulator instead of in_b.
- in_a  in  16  operand A.
- in_b  in  16  operand B.
- alu_rst  out  1  drives the ALU control rst.
- noOp  out  1  drives the ALU control noOp.
- cmd  out  5  drives the ALU control cmd; {in_acc_b, in_op}.
- op_a  out  16  operand to the A register.
- op_b  out  16  operand to the B register.
- alu_result  in  32  ALU output.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  32  captured result.
- res_op  out  4  opcode of the captured result.
- res_err  out  1  result is an error (reserved opcode or divide by zero).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: clr sampled low at a rising edge clears state on that edge.
  - FIFO is emptied; FSM goes to IDLE.
  - noOp=1, alu_rst=0, cmd=0, op_a=op_b=0.
  - res_valid=0, res_data=0, res_op=0, res_err=0, busy=0.
  - Any in-flight or held result is discarded.
- Input side:
  - in_ready = ~full, derived from registered state only.
  - A push occurs when in_valid & in_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, no push is accepted even if a pop occurs in that cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, FIFO non-empty: pop the head, register the outputs, then branch by opcode.
  - Valid op 0-11, not a divide by zero: cmd={acc_b, op}, op_a=a, op_b=b, noOp=0 → ISSUE.
  - op=12 (CLRACC): alu_rst=1 for exactly one cycle, noOp=1, no result produced → back to IDLE.
  - op=13-15: no ALU issue. res_data=0, res_err=1, res_op=op, res_valid=1 → HOLD.
  - op=3 with acc_b=0 and b=0: no ALU issue. res_data=32'hFFFF_FFFF, res_err=1, res_op=3, res_valid=1 → HOLD.
  - Divide by zero is not checked when acc_b=1.
- ISSUE/WAIT:
  - cmd, op_a, op_b and noOp=0 are held for ALU_LAT cycles.
  - On the edge ending the last held cycle: res_data=alu_result, res_op=op, res_err=0, res_valid=1, noOp=1, cmd=0 → HOLD.
- HOLD:
  - res_valid and res_data stay stable until res_ready is high.
  - On the handshake edge: res_valid=0 → IDLE.
  - A pop in IDLE happens no earlier than the next cycle.
- Latency (ALU_LAT=1, empty FIFO, idle, push accepted at edge N):
  - noOp=0 during cycle N+2.
  - res_valid=1 from cycle N+3.
  - Back-to-back throughput is one op per ALU_LAT+2 cycles with res_ready tied high.
- Invariants:
  - alu_rst and ~noOp are never high together.
  - noOp=1 whenever FSM ≠ ISSUE/WAIT.
- The FIFO pointers wrap modulo DEPTH; a separate count distinguishes full from empty.

Test Plan:
- Reset: drive clr=0 for 2 cycles mid-operation, then release → all outputs at reset values, in_ready=1, stale result never appears.
- ADD: in_op=0, in_a=16'h0003, in_b=16'h0004, ALU model returns a+b → noOp=0 at N+2, cmd=5'h00; res_valid at N+3 with res_data=32'h7, res_err=0.
- Divide by zero: in_op=3, in_b=0, acc_b=0 → noOp never falls; res_data=32'hFFFF_FFFF, res_err=1, res_op=3. With acc_b=1 the same request issues cmd=5'h13.
- CLRACC then reserved: push 12 then 14 → alu_rst high exactly one cycle, no result for op 12; op 14 yields res_data=0, res_err=1, res_op=14.
- FIFO full/backpressure: hold res_ready=0, push 6 MULT requests (3×5, ...) → in_ready drops after DEPTH+1 accepts (DEPTH queued plus one in flight). Then release res_ready → results arrive in push order, first res_data=32'hF, none lost or duplicated.
- ALU_LAT=3 build: SLL a=16'h0001, b=16'h0004 → cmd held 3 cycles with noOp=0, res_data=32'h10 sampled at the end of cycle 3.
